// File: rtl/link_sweep_ctrl_pkg.sv
// Shared control definitions for the link emulator TX FFE x RX CTLE sweep sequencer.
package link_sweep_ctrl_pkg;

  localparam int unsigned TX_SETTING_WIDTH = 4;
  localparam int unsigned RX_SETTING_WIDTH = 4;
  localparam int unsigned ERR_WIDTH        = 32;
  localparam int unsigned TIMEOUT_WIDTH    = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_RUN,
    ST_REPORT,
    ST_DONE
  } sweep_state_t;

  typedef struct packed {
    logic [TX_SETTING_WIDTH-1:0] tx;
    logic [RX_SETTING_WIDTH-1:0] rx;
    logic [ERR_WIDTH-1:0]        err;
    logic                        timeout;
  } sweep_res_t;

endpackage

// File: rtl/link_sweep_ctrl_if.sv
// Host, emulator and result-stream signals of the sweep sequencer.
interface link_sweep_ctrl_if
  import link_sweep_ctrl_pkg::*;
#(
  parameter int unsigned TX_W      = TX_SETTING_WIDTH,
  parameter int unsigned RX_W      = RX_SETTING_WIDTH,
  parameter int unsigned ERR_W     = ERR_WIDTH,
  parameter int unsigned TIMEOUT_W = TIMEOUT_WIDTH
) ();

  logic                 start;
  logic [TX_W-1:0]      tx_min;
  logic [TX_W-1:0]      tx_max;
  logic [RX_W-1:0]      rx_min;
  logic [RX_W-1:0]      rx_max;
  logic [TIMEOUT_W-1:0] timeout_lim;
  logic                 time_flag;
  logic [ERR_W-1:0]     err_count;
  logic                 emu_rst;
  logic [TX_W-1:0]      tx_setting;
  logic [RX_W-1:0]      rx_setting;
  logic                 res_valid;
  logic                 res_ready;
  logic [TX_W-1:0]      res_tx;
  logic [RX_W-1:0]      res_rx;
  logic [ERR_W-1:0]     res_err;
  logic                 res_timeout;
  logic [TX_W-1:0]      best_tx;
  logic [RX_W-1:0]      best_rx;
  logic [ERR_W-1:0]     best_err;
  logic                 busy;
  logic                 done;

  modport master (
    output start, tx_min, tx_max, rx_min, rx_max, timeout_lim,
    output time_flag, err_count, res_ready,
    input  emu_rst, tx_setting, rx_setting, res_valid, res_tx, res_rx,
    input  res_err, res_timeout, best_tx, best_rx, best_err, busy, done
  );

  modport slave (
    input  start, tx_min, tx_max, rx_min, rx_max, timeout_lim,
    input  time_flag, err_count, res_ready,
    output emu_rst, tx_setting, rx_setting, res_valid, res_tx, res_rx,
    output res_err, res_timeout, best_tx, best_rx, best_err, busy, done
  );

endinterface

// File: rtl/sweep_best_tracker.sv
// Compare-and-hold of the lowest-error sweep point; the first minimum seen is kept.
module sweep_best_tracker #(
  parameter int unsigned TX_W  = 4,
  parameter int unsigned RX_W  = 4,
  parameter int unsigned ERR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [TX_W-1:0]  clr_tx_i,
  input  logic [RX_W-1:0]  clr_rx_i,
  input  logic             upd_i,
  input  logic [TX_W-1:0]  cand_tx_i,
  input  logic [RX_W-1:0]  cand_rx_i,
  input  logic [ERR_W-1:0] cand_err_i,
  output logic [TX_W-1:0]  best_tx_o,
  output logic [RX_W-1:0]  best_rx_o,
  output logic [ERR_W-1:0] best_err_o
);

  logic [TX_W-1:0]  best_tx_q;
  logic [RX_W-1:0]  best_rx_q;
  logic [ERR_W-1:0] best_err_q;

  // All-ones error never wins, so an all-timeout sweep keeps the min point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_tx_q  <= '0;
      best_rx_q  <= '0;
      best_err_q <= '1;
    end else if (clr_i) begin
      best_tx_q  <= clr_tx_i;
      best_rx_q  <= clr_rx_i;
      best_err_q <= '1;
    end else if (upd_i && (cand_err_i < best_err_q)) begin
      best_tx_q  <= cand_tx_i;
      best_rx_q  <= cand_rx_i;
      best_err_q <= cand_err_i;
    end
  end

  assign best_tx_o  = best_tx_q;
  assign best_rx_o  = best_rx_q;
  assign best_err_o = best_err_q;

endmodule

// File: rtl/link_sweep_ctrl.sv
// Automated TX FFE x RX CTLE sweep: reset, run and score the link emulator per point.
module link_sweep_ctrl
  import link_sweep_ctrl_pkg::*;
#(
  parameter int unsigned TX_W       = TX_SETTING_WIDTH,
  parameter int unsigned RX_W       = RX_SETTING_WIDTH,
  parameter int unsigned ERR_W      = ERR_WIDTH,
  parameter int unsigned RST_CYCLES = 16,
  parameter int unsigned TIMEOUT_W  = TIMEOUT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  link_sweep_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);

  sweep_state_t         state_q, state_d;
  logic [TX_W-1:0]      tx_q, tx_d, tx_max_q, tx_max_d;
  logic [RX_W-1:0]      rx_q, rx_d, rx_min_q, rx_min_d, rx_max_q, rx_max_d;
  logic [CNT_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic [TIMEOUT_W-1:0] run_cnt_q, run_cnt_d;
  sweep_res_t           res_q, res_d;
  logic                 emu_rst_q, emu_rst_d;
  logic                 res_valid_q, res_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 start_c;
  logic                 hs_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      tx_max_q    <= '0;
      rx_min_q    <= '0;
      rx_max_q    <= '0;
      rst_cnt_q   <= '0;
      run_cnt_q   <= '0;
      res_q       <= '0;
      emu_rst_q   <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      tx_max_q    <= tx_max_d;
      rx_min_q    <= rx_min_d;
      rx_max_q    <= rx_max_d;
      rst_cnt_q   <= rst_cnt_d;
      run_cnt_q   <= run_cnt_d;
      res_q       <= res_d;
      emu_rst_q   <= emu_rst_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    tx_max_d  = tx_max_q;
    rx_min_d  = rx_min_q;
    rx_max_d  = rx_max_q;
    rst_cnt_d = rst_cnt_q;
    run_cnt_d = run_cnt_q;
    res_d     = res_q;
    start_c   = 1'b0;
    hs_c      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // Inverted bounds collapse the axis onto its min value.
        if (bus.start) begin
          start_c   = 1'b1;
          tx_d      = bus.tx_min;
          rx_d      = bus.rx_min;
          rx_min_d  = bus.rx_min;
          tx_max_d  = (bus.tx_min > bus.tx_max) ? bus.tx_min : bus.tx_max;
          rx_max_d  = (bus.rx_min > bus.rx_max) ? bus.rx_min : bus.rx_max;
          rst_cnt_d = '0;
          state_d   = ST_APPLY;
        end
      end
      ST_APPLY: begin
        if (rst_cnt_q == RST_LAST) begin
          run_cnt_d = '0;
          state_d   = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.time_flag) begin
          res_d   = '{tx: TX_SETTING_WIDTH'(tx_q), rx: RX_SETTING_WIDTH'(rx_q),
                      err: ERR_WIDTH'(bus.err_count), timeout: 1'b0};
          state_d = ST_REPORT;
        end else if ((bus.timeout_lim != '0) && (run_cnt_q == bus.timeout_lim)) begin
          res_d   = '{tx: TX_SETTING_WIDTH'(tx_q), rx: RX_SETTING_WIDTH'(rx_q),
                      err: '1, timeout: 1'b1};
          state_d = ST_REPORT;
        end else begin
          run_cnt_d = run_cnt_q + TIMEOUT_W'(1);
        end
      end
      ST_REPORT: begin
        if (bus.res_ready) begin
          hs_c      = 1'b1;
          rst_cnt_d = '0;
          if (rx_q == rx_max_q) begin
            if (tx_q == tx_max_q) begin
              state_d = ST_DONE;
            end else begin
              tx_d    = tx_q + TX_W'(1);
              rx_d    = rx_min_q;
              state_d = ST_APPLY;
            end
          end else begin
            rx_d    = rx_q + RX_W'(1);
            state_d = ST_APPLY;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    emu_rst_d   = (state_d != ST_RUN);
    res_valid_d = (state_d == ST_REPORT);
    busy_d      = (state_d == ST_APPLY) || (state_d == ST_RUN) || (state_d == ST_REPORT);
    done_d      = (state_d == ST_DONE);
  end

  sweep_best_tracker #(
    .TX_W  (TX_W),
    .RX_W  (RX_W),
    .ERR_W (ERR_W)
  ) u_best (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (start_c),
    .clr_tx_i   (bus.tx_min),
    .clr_rx_i   (bus.rx_min),
    .upd_i      (hs_c),
    .cand_tx_i  (TX_W'(res_q.tx)),
    .cand_rx_i  (RX_W'(res_q.rx)),
    .cand_err_i (ERR_W'(res_q.err)),
    .best_tx_o  (bus.best_tx),
    .best_rx_o  (bus.best_rx),
    .best_err_o (bus.best_err)
  );

  assign bus.emu_rst     = emu_rst_q;
  assign bus.tx_setting  = tx_q;
  assign bus.rx_setting  = rx_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_tx      = TX_W'(res_q.tx);
  assign bus.res_rx      = RX_W'(res_q.rx);
  assign bus.res_err     = ERR_W'(res_q.err);
  assign bus.res_timeout = res_q.timeout;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_link_sweep_ctrl.sv
// Directed self-checking bench for link_sweep_ctrl; the bench plays the link emulator.
module tb_link_sweep_ctrl;

  localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  link_sweep_ctrl_if #(.TX_W(4), .RX_W(4), .ERR_W(32), .TIMEOUT_W(32)) bus ();

  link_sweep_ctrl #(
    .TX_W       (4),
    .RX_W       (4),
    .ERR_W      (32),
    .RST_CYCLES (4),
    .TIMEOUT_W  (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_bounds(input logic [3:0] txl, input logic [3:0] txh,
                            input logic [3:0] rxl, input logic [3:0] rxh);
    bus.tx_min = txl;
    bus.tx_max = txh;
    bus.rx_min = rxl;
    bus.rx_max = rxh;
  endtask

  // Entered on the first APPLY negedge; returns on the negedge after the handshake.
  task automatic run_point(input logic [3:0] etx, input logic [3:0] erx, input int dly,
                           input logic [31:0] err, input int exp_lat, input int hold);
    int n;
    logic [31:0] exp_err;
    logic        exp_to;
    exp_err = (dly < 0) ? ALL1 : err;
    exp_to  = (dly < 0);
    n = 0;
    while (bus.emu_rst === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("apply_len", 64'(n), 64'd4);
    check("tx_setting", 64'(bus.tx_setting), 64'(etx));
    check("rx_setting", 64'(bus.rx_setting), 64'(erx));
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 1000) begin
      if (dly >= 0 && n == dly) begin
        bus.time_flag = 1'b1;
        bus.err_count = err;
      end
      n++;
      @(negedge clk);
    end
    bus.time_flag = 1'b0;
    check("run_latency", 64'(n), 64'(exp_lat));
    check("res_tx", 64'(bus.res_tx), 64'(etx));
    check("res_rx", 64'(bus.res_rx), 64'(erx));
    check("res_err", 64'(bus.res_err), 64'(exp_err));
    check("res_timeout", 64'(bus.res_timeout), 64'(exp_to));
    check("report_emu_rst", 64'(bus.emu_rst), 64'd1);
    if (hold > 0) begin
      bus.res_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("bp_valid", 64'(bus.res_valid), 64'd1);
        check("bp_err", 64'(bus.res_err), 64'(exp_err));
        check("bp_rx", 64'(bus.res_rx), 64'(erx));
        check("bp_emu_rst", 64'(bus.emu_rst), 64'd1);
      end
      bus.res_ready = 1'b1;
    end
    @(negedge clk);
    check("valid_drop", 64'(bus.res_valid), 64'd0);
  endtask

  task automatic check_best(input logic [3:0] btx, input logic [3:0] brx, input logic [31:0] berr);
    check("best_tx", 64'(bus.best_tx), 64'(btx));
    check("best_rx", 64'(bus.best_rx), 64'(brx));
    check("best_err", 64'(bus.best_err), 64'(berr));
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_busy", 64'(bus.busy), 64'd1);
  endtask

  initial begin
    int n;
    bus.start       = 1'b0;
    bus.time_flag   = 1'b0;
    bus.err_count   = '0;
    bus.res_ready   = 1'b1;
    bus.timeout_lim = '0;
    set_bounds(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (2) @(negedge clk);

    check("rst_emu_rst", 64'(bus.emu_rst), 64'd1);
    check("rst_tx", 64'(bus.tx_setting), 64'd0);
    check("rst_rx", 64'(bus.rx_setting), 64'd0);
    check("rst_valid", 64'(bus.res_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_res_err", 64'(bus.res_err), 64'd0);
    check_best(4'd0, 4'd0, ALL1);
    rst = 1'b0;
    @(negedge clk);

    // Single point
    set_bounds(4'd3, 4'd3, 4'd5, 4'd5);
    pulse_start();
    run_point(4'd3, 4'd5, 10, 32'd7, 11, 0);
    check("single_done", 64'(bus.done), 64'd1);
    check("single_busy", 64'(bus.busy), 64'd0);
    check_best(4'd3, 4'd5, 32'd7);

    // 2x3 sweep, restarted from DONE; start held high with scrambled bounds while busy
    set_bounds(4'd0, 4'd1, 4'd2, 4'd4);
    pulse_start();
    bus.start = 1'b1;
    set_bounds(4'd9, 4'd0, 4'd9, 4'd2);
    run_point(4'd0, 4'd2, 3, 32'd9, 4, 0);
    run_point(4'd0, 4'd3, 2, 32'd4, 3, 0);
    run_point(4'd0, 4'd4, 5, 32'd4, 6, 0);
    check_best(4'd0, 4'd3, 32'd4);
    run_point(4'd1, 4'd2, 0, 32'd6, 1, 0);
    run_point(4'd1, 4'd3, 1, 32'd1, 2, 0);
    bus.start = 1'b0;
    run_point(4'd1, 4'd4, 4, 32'd8, 5, 0);
    check("sweep_done", 64'(bus.done), 64'd1);
    check_best(4'd1, 4'd3, 32'd1);

    // Backpressure
    set_bounds(4'd4, 4'd4, 4'd6, 4'd7);
    pulse_start();
    run_point(4'd4, 4'd6, 2, 32'd3, 3, 5);
    check("bp_next_rx", 64'(bus.rx_setting), 64'd7);
    check("bp_next_busy", 64'(bus.busy), 64'd1);
    check("bp_next_emu_rst", 64'(bus.emu_rst), 64'd1);
    run_point(4'd4, 4'd7, 1, 32'd2, 2, 0);
    check_best(4'd4, 4'd7, 32'd2);

    // Timeout
    bus.timeout_lim = 32'd20;
    set_bounds(4'd2, 4'd2, 4'd1, 4'd1);
    pulse_start();
    run_point(4'd2, 4'd1, -1, 32'd0, 21, 0);
    check("to_done", 64'(bus.done), 64'd1);
    check_best(4'd2, 4'd1, ALL1);
    bus.timeout_lim = '0;

    // Reset during RUN of the second point
    set_bounds(4'd0, 4'd0, 4'd0, 4'd1);
    pulse_start();
    run_point(4'd0, 4'd0, 1, 32'd5, 2, 0);
    n = 0;
    while (bus.emu_rst === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("mid_rx", 64'(bus.rx_setting), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_emu_rst", 64'(bus.emu_rst), 64'd1);
    check("mid_busy", 64'(bus.busy), 64'd0);
    check("mid_valid", 64'(bus.res_valid), 64'd0);
    check("mid_tx", 64'(bus.tx_setting), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(bus.res_valid), 64'd0);
    pulse_start();
    run_point(4'd0, 4'd0, 2, 32'd5, 3, 0);
    run_point(4'd0, 4'd1, 2, 32'd3, 3, 0);
    check("resweep_done", 64'(bus.done), 64'd1);
    check_best(4'd0, 4'd1, 32'd3);

    // Inverted bounds
    set_bounds(4'd5, 4'd2, 4'd1, 4'd0);
    pulse_start();
    run_point(4'd5, 4'd1, 0, 32'd2, 1, 0);
    check("inv_done", 64'(bus.done), 64'd1);
    check("inv_busy", 64'(bus.busy), 64'd0);
    check_best(4'd5, 4'd1, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
